free_list_ctrl: RTL and testbench

Controller that sequences the physical-register free list.
- Grants rename-stage allocation requests and forwards ROB-commit releases, filtering p0.
- Owns the branch checkpoint table of free-list read pointers; issues branch tags in age order.
- On a mispredict it drives a one-cycle restore into the free list, then a one-cycle recover stall before allocation resumes.

---
 rtl/free_list_ctrl_pkg.sv | 15 +
 rtl/free_list_ctrl_ckpt_table.sv | 71 +++++++
 rtl/free_list_ctrl.sv | 111 +++++++++++
 tb/tb_free_list_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/free_list_ctrl_pkg.sv
// Shared sizing and state type for the physical-register free-list controller.
package free_list_ctrl_pkg;

   localparam int unsigned PHYSICAL_REG_FILE_LENGTH = 6;
   localparam int unsigned FREE_LIST_PTR_WIDTH      = 5;
   localparam int unsigned NUM_CKPT                 = 4;
   localparam int unsigned TAG_W                    = $clog2(NUM_CKPT);

   typedef enum logic [1:0] {
      StRun,
      StFlush,
      StRecover
   } fl_ctrl_state_t;

endpackage

// File: rtl/free_list_ctrl_ckpt_table.sv
// Branch checkpoint table: saved free-list read pointers, live-tag mask and
// allocation tail, with circular squash of a mispredicted tag and everything younger.
module free_list_ctrl_ckpt_table
   import free_list_ctrl_pkg::*;
#(
   parameter int unsigned PTR_W = FREE_LIST_PTR_WIDTH + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                take_i,
   input  logic [PTR_W-1:0]    take_ptr_i,
   input  logic                clear_i,
   input  logic [TAG_W-1:0]    clear_tag_i,
   input  logic                squash_i,
   input  logic [TAG_W-1:0]    squash_tag_i,
   input  logic [TAG_W-1:0]    rd_tag_i,
   output logic [PTR_W-1:0]    rd_ptr_o,
   output logic [TAG_W-1:0]    tail_o,
   output logic [NUM_CKPT-1:0] valid_o
);

   logic [PTR_W-1:0]    ckpt_q [NUM_CKPT];
   logic [PTR_W-1:0]    ckpt_d [NUM_CKPT];
   logic [NUM_CKPT-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]    tail_q, tail_d;
   logic [TAG_W-1:0]    span;

   assign span = tail_q - squash_tag_i;

   always_comb begin
      ckpt_d  = ckpt_q;
      valid_d = valid_q;
      tail_d  = tail_q;
      if (take_i) begin
         ckpt_d[tail_q]  = take_ptr_i;
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      if (clear_i) begin
         valid_d[clear_tag_i] = 1'b0;
      end
      if (squash_i) begin
         // span==0 with a live squash tag means the table is full: clear all.
         for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            if ((span == '0) || ((TAG_W'(i) - squash_tag_i) < span)) begin
               valid_d[i] = 1'b0;
            end
         end
         tail_d = squash_tag_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            ckpt_q[i] <= '0;
         end
         valid_q <= '0;
         tail_q  <= '0;
      end else begin
         ckpt_q  <= ckpt_d;
         valid_q <= valid_d;
         tail_q  <= tail_d;
      end
   end

   assign rd_ptr_o = ckpt_q[rd_tag_i];
   assign tail_o   = tail_q;
   assign valid_o  = valid_q;

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list sequencer: grants rename allocations, forwards commit releases,
// tags branches and drives flush/recover after a mispredict.
module free_list_ctrl
   import free_list_ctrl_pkg::*;
#(
   parameter int unsigned PREG_W = PHYSICAL_REG_FILE_LENGTH,
   parameter int unsigned PTR_W  = FREE_LIST_PTR_WIDTH + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              alloc_req_i,
   output logic              alloc_gnt_o,
   output logic [PREG_W-1:0] alloc_preg_o,
   input  logic              rel_valid_i,
   input  logic [PREG_W-1:0] rel_preg_i,
   input  logic              br_alloc_i,
   output logic [TAG_W-1:0]  br_tag_o,
   output logic              ckpt_full_o,
   input  logic              br_resolve_i,
   input  logic [TAG_W-1:0]  br_resolve_tag_i,
   input  logic              br_mispredict_i,
   output logic              fl_read_en_o,
   input  logic [PREG_W-1:0] fl_read_data_i,
   input  logic              fl_read_ack_i,
   input  logic              fl_empty_i,
   output logic              fl_write_en_o,
   output logic [PREG_W-1:0] fl_write_data_o,
   input  logic [PTR_W-1:0]  fl_rd_ptr_i,
   output logic              fl_flush_o,
   output logic [PTR_W-1:0]  fl_restore_ptr_o,
   output logic              recovering_o
);

   fl_ctrl_state_t      state_q, state_d;
   logic [PTR_W-1:0]    restore_q, restore_d;
   logic                run;
   logic                mispredict;
   logic                resolve_ok;
   logic                take;
   logic [PTR_W-1:0]    take_ptr;
   logic [PTR_W-1:0]    ckpt_ptr;
   logic [TAG_W-1:0]    tail;
   logic [NUM_CKPT-1:0] valid;

   assign run = (state_q == StRun);

   assign fl_read_en_o = run & alloc_req_i & ~fl_empty_i;
   assign alloc_gnt_o  = fl_read_en_o & fl_read_ack_i;
   assign alloc_preg_o = alloc_gnt_o ? fl_read_data_i : '0;

   // p0 is hard-wired and never returns to the free list.
   assign fl_write_en_o   = rel_valid_i & (rel_preg_i != '0);
   assign fl_write_data_o = rel_preg_i;

   assign br_tag_o    = tail;
   assign ckpt_full_o = valid[tail];

   assign mispredict = run & br_resolve_i & br_mispredict_i & valid[br_resolve_tag_i];
   assign resolve_ok = run & br_resolve_i & ~br_mispredict_i;
   assign take       = run & br_alloc_i & ~ckpt_full_o & ~mispredict;
   // Checkpoint reflects the pointer after this cycle's pop.
   assign take_ptr   = fl_rd_ptr_i + PTR_W'(alloc_gnt_o);

   free_list_ctrl_ckpt_table #(
      .PTR_W (PTR_W)
   ) u_ckpt_table (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .take_i       (take),
      .take_ptr_i   (take_ptr),
      .clear_i      (resolve_ok),
      .clear_tag_i  (br_resolve_tag_i),
      .squash_i     (mispredict),
      .squash_tag_i (br_resolve_tag_i),
      .rd_tag_i     (br_resolve_tag_i),
      .rd_ptr_o     (ckpt_ptr),
      .tail_o       (tail),
      .valid_o      (valid)
   );

   always_comb begin
      state_d   = state_q;
      restore_d = restore_q;
      unique case (state_q)
         StRun: begin
            if (mispredict) begin
               state_d   = StFlush;
               restore_d = ckpt_ptr;
            end
         end
         StFlush:   state_d = StRecover;
         StRecover: state_d = StRun;
         default:   state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StRun;
         restore_q <= '0;
      end else begin
         state_q   <= state_d;
         restore_q <= restore_d;
      end
   end

   assign fl_flush_o       = (state_q == StFlush);
   assign fl_restore_ptr_o = fl_flush_o ? restore_q : '0;
   assign recovering_o     = ~run;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed self-checking bench for free_list_ctrl.
module tb_free_list_ctrl;
   import free_list_ctrl_pkg::*;

   localparam int unsigned PREG_W = PHYSICAL_REG_FILE_LENGTH;
   localparam int unsigned PTR_W  = FREE_LIST_PTR_WIDTH + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              alloc_req, alloc_gnt;
   logic [PREG_W-1:0] alloc_preg;
   logic              rel_valid;
   logic [PREG_W-1:0] rel_preg;
   logic              br_alloc;
   logic [TAG_W-1:0]  br_tag;
   logic              ckpt_full;
   logic              br_resolve;
   logic [TAG_W-1:0]  br_resolve_tag;
   logic              br_mispredict;
   logic              fl_read_en;
   logic [PREG_W-1:0] fl_read_data;
   logic              fl_read_ack, fl_empty;
   logic              fl_write_en;
   logic [PREG_W-1:0] fl_write_data;
   logic [PTR_W-1:0]  fl_rd_ptr;
   logic              fl_flush;
   logic [PTR_W-1:0]  fl_restore_ptr;
   logic              recovering;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   free_list_ctrl dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .alloc_req_i      (alloc_req),
      .alloc_gnt_o      (alloc_gnt),
      .alloc_preg_o     (alloc_preg),
      .rel_valid_i      (rel_valid),
      .rel_preg_i       (rel_preg),
      .br_alloc_i       (br_alloc),
      .br_tag_o         (br_tag),
      .ckpt_full_o      (ckpt_full),
      .br_resolve_i     (br_resolve),
      .br_resolve_tag_i (br_resolve_tag),
      .br_mispredict_i  (br_mispredict),
      .fl_read_en_o     (fl_read_en),
      .fl_read_data_i   (fl_read_data),
      .fl_read_ack_i    (fl_read_ack),
      .fl_empty_i       (fl_empty),
      .fl_write_en_o    (fl_write_en),
      .fl_write_data_o  (fl_write_data),
      .fl_rd_ptr_i      (fl_rd_ptr),
      .fl_flush_o       (fl_flush),
      .fl_restore_ptr_o (fl_restore_ptr),
      .recovering_o     (recovering)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [TAG_W-1:0] tag, input logic mis);
      br_resolve     = 1'b1;
      br_resolve_tag = tag;
      br_mispredict  = mis;
      tick();
      br_resolve     = 1'b0;
      br_mispredict  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; alloc_req = 0; rel_valid = 0; rel_preg = '0; br_alloc = 0;
      br_resolve = 0; br_resolve_tag = '0; br_mispredict = 0;
      fl_read_data = '0; fl_read_ack = 0; fl_empty = 0; fl_rd_ptr = '0;
      #3;
      chk("rst_gnt", 32'(alloc_gnt), 0);
      chk("rst_rd_en", 32'(fl_read_en), 0);
      chk("rst_wr_en", 32'(fl_write_en), 0);
      chk("rst_flush", 32'(fl_flush), 0);
      chk("rst_tag", 32'(br_tag), 0);
      chk("rst_full", 32'(ckpt_full), 0);
      chk("rst_recov", 32'(recovering), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Zero-latency grant, then blocked by empty.
      alloc_req = 1; fl_read_data = 33; fl_read_ack = 1; #1;
      chk("alloc_rd_en", 32'(fl_read_en), 1);
      chk("alloc_gnt", 32'(alloc_gnt), 1);
      chk("alloc_preg", 32'(alloc_preg), 33);
      fl_empty = 1; #1;
      chk("empty_rd_en", 32'(fl_read_en), 0);
      chk("empty_gnt", 32'(alloc_gnt), 0);
      chk("empty_preg", 32'(alloc_preg), 0);
      fl_empty = 0; alloc_req = 0;
      rel_valid = 1; rel_preg = '0; #1;
      chk("rel_p0", 32'(fl_write_en), 0);
      rel_valid = 0;

      // Fill the checkpoint table: ptrs 6,10,20,30.
      br_alloc = 1; fl_rd_ptr = 5; alloc_req = 1; #1;
      chk("br0_tag", 32'(br_tag), 0);
      chk("br0_gnt", 32'(alloc_gnt), 1);
      tick();
      alloc_req = 0; fl_rd_ptr = 10; #1;
      chk("br1_tag", 32'(br_tag), 1);
      tick();
      fl_rd_ptr = 20; tick();
      fl_rd_ptr = 30; tick();
      chk("full_set", 32'(ckpt_full), 1);
      chk("full_tag", 32'(br_tag), 0);
      tick();
      chk("drop_tag", 32'(br_tag), 0);
      chk("drop_full", 32'(ckpt_full), 1);
      br_alloc = 0;

      // Retire tag 3 correctly, then mispredict tag 1.
      resolve(2'd3, 1'b0);
      chk("ok3_full", 32'(ckpt_full), 1);
      resolve(2'd1, 1'b1);
      alloc_req = 1; rel_valid = 1; rel_preg = 40; #1;
      chk("fl_flush", 32'(fl_flush), 1);
      chk("fl_restore1", 32'(fl_restore_ptr), 10);
      chk("fl_recov", 32'(recovering), 1);
      chk("fl_rd_en", 32'(fl_read_en), 0);
      chk("fl_gnt", 32'(alloc_gnt), 0);
      chk("fl_wr_en", 32'(fl_write_en), 1);
      chk("fl_wr_data", 32'(fl_write_data), 40);
      tick();
      rel_valid = 0;
      chk("rc_flush", 32'(fl_flush), 0);
      chk("rc_restore", 32'(fl_restore_ptr), 0);
      chk("rc_recov", 32'(recovering), 1);
      chk("rc_gnt", 32'(alloc_gnt), 0);
      tick();
      chk("run_recov", 32'(recovering), 0);
      chk("run_gnt", 32'(alloc_gnt), 1);
      chk("mp1_tail", 32'(br_tag), 1);
      chk("mp1_full", 32'(ckpt_full), 0);
      alloc_req = 0;

      // Mispredict tag 0 exposes the first checkpoint (5 + grant).
      resolve(2'd0, 1'b1);
      chk("restore0", 32'(fl_restore_ptr), 6);
      tick(); tick();
      chk("mp0_tail", 32'(br_tag), 0);
      chk("mp0_full", 32'(ckpt_full), 0);

      // Move tail to 3, then make tags 3 and 0 live (tail=1).
      br_alloc = 1; fl_rd_ptr = 0;
      tick(); tick(); tick();
      br_alloc = 0;
      resolve(2'd0, 1'b0); resolve(2'd1, 1'b0); resolve(2'd2, 1'b0);
      chk("wrap_tail3", 32'(br_tag), 3);
      br_alloc = 1; fl_rd_ptr = 7; tick();
      fl_rd_ptr = 8; tick();
      chk("wrap_tail1", 32'(br_tag), 1);
      // Mispredict tag 3 with a competing br_alloc, which must be dropped.
      resolve(2'd3, 1'b1);
      br_alloc = 0;
      chk("wrap_flush", 32'(fl_flush), 1);
      chk("wrap_restore", 32'(fl_restore_ptr), 7);
      tick(); tick();
      chk("wrap_tag", 32'(br_tag), 3);
      chk("wrap_full3", 32'(ckpt_full), 0);
      br_alloc = 1; fl_rd_ptr = 0; tick();
      chk("wrap_tag0", 32'(br_tag), 0);
      chk("wrap_full0", 32'(ckpt_full), 0);
      tick();
      chk("wrap_tag1", 32'(br_tag), 1);
      chk("wrap_full1", 32'(ckpt_full), 0);
      br_alloc = 0;

      // Async reset in the middle of a flush.
      resolve(2'd3, 1'b1);
      chk("pre_rst_flush", 32'(fl_flush), 1);
      rst_n = 1'b0; #1;
      chk("arst_flush", 32'(fl_flush), 0);
      chk("arst_recov", 32'(recovering), 0);
      chk("arst_restore", 32'(fl_restore_ptr), 0);
      chk("arst_tag", 32'(br_tag), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_flush", 32'(fl_flush), 0);
      chk("post_rst_recov", 32'(recovering), 0);
      tick();
      chk("post_rst_flush2", 32'(fl_flush), 0);
      alloc_req = 1; #1;
      chk("post_rst_gnt", 32'(alloc_gnt), 1);
      alloc_req = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
